// File: rtl/midi_note_decoder_pkg.sv
`default_nettype none
// =============================================================================
// Module      : midi_note_decoder_pkg
// Description : Parser state encoding and MIDI byte/status constants shared by
//               the note decoder and its timeout counter.
// Revision    : 1.0
// =============================================================================
package midi_note_decoder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_D1   = 4'b0010,
        ST_D2   = 4'b0100,
        ST_SYSX = 4'b1000
    } parse_state_t;

    localparam logic [3:0] NOTE_OFF      = 4'h8;
    localparam logic [3:0] NOTE_ON       = 4'h9;
    localparam logic [3:0] PROG_CHANGE   = 4'hC;
    localparam logic [3:0] CHAN_PRESSURE = 4'hD;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [7:0] SYSTEM_MIN   = 8'hF0;
    localparam logic [7:0] STATUS_MIN   = 8'h80;

    // Number of data bytes that follow a channel status byte.
    function automatic logic [1:0] msg_data_len(input logic [3:0] kind);
        return ((kind == PROG_CHANGE) || (kind == CHAN_PRESSURE)) ? 2'd1 : 2'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/midi_note_decoder_if.sv
`default_nettype none
// =============================================================================
// Module      : midi_note_decoder_if
// Description : Byte-stream input and note-event output bundle of the decoder.
// Revision    : 1.0
// =============================================================================
interface midi_note_decoder_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       channel_ld;
    logic [3:0] channel_in;
    logic       note_on;
    logic       note_off;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       active;
    logic       err_timeout;

    modport master (
        output rx_valid, rx_data, channel_ld, channel_in,
        input  note_on, note_off, note, velocity, active, err_timeout
    );

    modport slave (
        input  rx_valid, rx_data, channel_ld, channel_in,
        output note_on, note_off, note, velocity, active, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/midi_note_decoder_timeout.sv
`default_nettype none
// =============================================================================
// Module      : midi_timeout_counter
// Description : Saturating inter-byte counter; strobes expire at TIMEOUT_CYCLES-1.
// Revision    : 1.0
// =============================================================================
module midi_timeout_counter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000
) (
    input  wire logic clk,
    input  wire logic rst_b,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expire
);
    localparam logic [31:0] LIMIT = TIMEOUT_CYCLES - 32'd1;

    logic [31:0] r_count;

    // A fresh byte in the same cycle always wins over expiry.
    assign expire = enable && !clear && (r_count == LIMIT);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (enable && (r_count != '1)) begin
            r_count <= r_count + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/midi_note_decoder.sv
`default_nettype none
// =============================================================================
// Module      : midi_note_decoder
// Description : Monophonic last-note-priority MIDI note parser. Define
//               OMNI_MODE_EN to respond to note messages on every channel.
// Revision    : 1.0
// =============================================================================
import midi_note_decoder_pkg::*;

module midi_note_decoder #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3_000_000,
    parameter logic [3:0]  CHANNEL_RST    = 4'd0
) (
    input wire logic            clk,
    input wire logic            rst_b,
    midi_note_decoder_if.slave  bus
);
    parse_state_t r_state;
    logic [7:0]   r_status;
    logic [6:0]   r_d1;
    logic [6:0]   r_note;
    logic [6:0]   r_velocity;
    logic         r_active;
    logic         r_note_on;
    logic         r_note_off;
    logic         r_err_timeout;

    logic       w_rt, w_sys, w_stat, w_data, w_nonrt;
    logic       w_complete, w_chan_ok, w_start, w_release, w_expire;
    logic [3:0] w_kind;
    logic [6:0] w_msg_d1, w_msg_d2;

    assign w_rt     = bus.rx_valid && (bus.rx_data >= REALTIME_MIN);
    assign w_sys    = bus.rx_valid && (bus.rx_data >= SYSTEM_MIN) && !w_rt;
    assign w_stat   = bus.rx_valid && (bus.rx_data >= STATUS_MIN) && (bus.rx_data < SYSTEM_MIN);
    assign w_data   = bus.rx_valid && !bus.rx_data[7];
    assign w_nonrt  = bus.rx_valid && !w_rt;
    assign w_kind   = r_status[7:4];

    assign w_complete = w_data && ((r_state == ST_D2) ||
                        ((r_state == ST_D1) && (msg_data_len(w_kind) == 2'd1)));
    assign w_msg_d1   = (r_state == ST_D2) ? r_d1 : bus.rx_data[6:0];
    assign w_msg_d2   = bus.rx_data[6:0];

`ifdef OMNI_MODE_EN
    assign w_chan_ok = 1'b1;
`else
    logic [3:0] r_channel;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_channel <= CHANNEL_RST;
        end else if (bus.channel_ld) begin
            r_channel <= bus.channel_in;
        end
    end

    assign w_chan_ok = (r_status[3:0] == r_channel);
`endif

    // Note-on with velocity 0 is a release by MIDI convention.
    assign w_start   = w_complete && w_chan_ok && (w_kind == NOTE_ON) && (w_msg_d2 != 7'd0);
    assign w_release = w_complete && w_chan_ok && r_active && (w_msg_d1 == r_note) &&
                       ((w_kind == NOTE_OFF) || ((w_kind == NOTE_ON) && (w_msg_d2 == 7'd0)));

    midi_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_b  (rst_b),
        .clear  (w_nonrt),
        .enable (r_state == ST_D2),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= ST_IDLE;
            r_status      <= '0;
            r_d1          <= '0;
            r_note        <= '0;
            r_velocity    <= '0;
            r_active      <= 1'b0;
            r_note_on     <= 1'b0;
            r_note_off    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_note_on     <= w_start;
            r_note_off    <= w_release;
            r_err_timeout <= w_expire;

            if (w_start) begin
                r_note     <= w_msg_d1;
                r_velocity <= w_msg_d2;
                r_active   <= 1'b1;
            end else if (w_release) begin
                r_active   <= 1'b0;
            end

            if (w_sys) begin
                r_state  <= ST_SYSX;
                r_status <= '0;
            end else if (w_stat) begin
                r_state  <= ST_D1;
                r_status <= bus.rx_data;
            end else if (w_data) begin
                case (r_state)
                    ST_D1: begin
                        if (msg_data_len(w_kind) == 2'd2) begin
                            r_d1    <= bus.rx_data[6:0];
                            r_state <= ST_D2;
                        end
                    end
                    ST_D2:   r_state <= ST_D1;
                    default: r_state <= r_state;
                endcase
            end else if (w_expire) begin
                r_state <= ST_D1;
            end
        end
    end

    assign bus.note_on     = r_note_on;
    assign bus.note_off    = r_note_off;
    assign bus.note        = r_note;
    assign bus.velocity    = r_velocity;
    assign bus.active      = r_active;
    assign bus.err_timeout = r_err_timeout;
endmodule
`default_nettype wire

// File: tb/tb_midi_note_decoder.sv
`default_nettype none
// =============================================================================
// Module      : tb_midi_note_decoder
// Description : Directed byte streams checked cycle-by-cycle against a
//               message-level model, plus literal expectations.
// Revision    : 1.0
// =============================================================================
module tb_midi_note_decoder;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   errors = 0;
    int   checks = 0;

    midi_note_decoder_if bus();

    midi_note_decoder #(
        .TIMEOUT_CYCLES (32'd16),
        .CHANNEL_RST    (4'd0)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: message-level view of the byte stream.
    logic [7:0] m_status = 8'h00;
    logic [6:0] m_q[$];
    int         m_gap = 0;
    logic [3:0] m_chan = 4'd0;
    logic       e_on = 0, e_off = 0, e_to = 0, e_active = 0;
    logic [6:0] e_note = 0, e_vel = 0;

    function automatic int need_bytes(input logic [7:0] s);
        return (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 1 : 2;
    endfunction

    function automatic logic chan_match(input logic [3:0] c, input logic [3:0] reg_c);
`ifdef OMNI_MODE_EN
        return 1'b1;
`else
        return c == reg_c;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_b);
            if (!rst_b) begin
                m_status = 0; m_q.delete(); m_gap = 0; m_chan = 4'd0;
                e_on = 0; e_off = 0; e_to = 0; e_active = 0; e_note = 0; e_vel = 0;
            end else begin
                automatic logic awaiting2 = (m_status != 0) && (need_bytes(m_status) == 2) && (m_q.size() == 1);
                automatic logic fresh = bus.rx_valid && (bus.rx_data < 8'hF8);
                e_on = 0; e_off = 0; e_to = 0;
                if (fresh) begin
                    automatic logic [7:0] b = bus.rx_data;
                    m_gap = 0;
                    if (b >= 8'hF0) begin
                        m_status = 0; m_q.delete();
                    end else if (b >= 8'h80) begin
                        m_status = b; m_q.delete();
                    end else if (m_status != 0) begin
                        m_q.push_back(b[6:0]);
                        if (m_q.size() == need_bytes(m_status)) begin
                            if (chan_match(m_status[3:0], m_chan) && m_q.size() == 2) begin
                                if (m_status[7:4] == 4'h9 && m_q[1] != 0) begin
                                    e_note = m_q[0]; e_vel = m_q[1]; e_active = 1; e_on = 1;
                                end else if ((m_status[7:4] == 4'h8 || m_status[7:4] == 4'h9)
                                             && e_active && m_q[0] == e_note) begin
                                    e_active = 0; e_off = 1;
                                end
                            end
                            m_q.delete();
                        end
                    end
                end else if (awaiting2) begin
                    m_gap++;
                    if (m_gap == TMO) begin
                        m_q.delete(); m_gap = 0; e_to = 1;
                    end
                end
                if (bus.channel_ld) m_chan = bus.channel_in;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            checks++;
            if ({bus.note_on, bus.note_off, bus.note, bus.velocity, bus.active, bus.err_timeout} !==
                {e_on, e_off, e_note, e_vel, e_active, e_to} || (bus.note_on && bus.note_off)) begin
                errors++;
                $display("FAIL model t=%0t got on=%b off=%b note=%0d vel=%0d act=%b to=%b exp on=%b off=%b note=%0d vel=%0d act=%b to=%b",
                         $time, bus.note_on, bus.note_off, bus.note, bus.velocity, bus.active, bus.err_timeout,
                         e_on, e_off, e_note, e_vel, e_active, e_to);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_chan(input logic [3:0] c);
        @(negedge clk);
        bus.channel_ld = 1'b1;
        bus.channel_in = c;
        @(negedge clk);
        bus.channel_ld = 1'b0;
    endtask

    initial begin
        bus.rx_valid = 0; bus.rx_data = 0; bus.channel_ld = 0; bus.channel_in = 0;
        idle(3);
        chk("reset_active", bus.active, 0);
        chk("reset_note", bus.note, 0);
        rst_b = 1'b1;
        load_chan(4'd0);

        send(8'h90); send(8'h3C); send(8'h64);
        chk("on_pulse", bus.note_on, 1);
        chk("on_note", bus.note, 60);
        chk("on_vel", bus.velocity, 100);
        chk("on_active", bus.active, 1);
        send(8'h80); send(8'h3C); send(8'h00);
        chk("off_pulse", bus.note_off, 1);
        chk("off_active", bus.active, 0);

        send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
        chk("rs_on", bus.note_on, 1);
        chk("rs_no_off", bus.note_off, 0);
        chk("rs_note", bus.note, 62);
        chk("rs_vel", bus.velocity, 80);
        send(8'h3C); send(8'h00);
        chk("rs_stale_off", bus.note_off, 0);
        chk("rs_still_active", bus.active, 1);
        send(8'h3E); send(8'h00);
        chk("rs_vel0_off", bus.note_off, 1);

        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        chk("rt_on", bus.note_on, 1);
        chk("rt_note", bus.note, 60);
        send(8'h80); send(8'h3C); send(8'h00);

        send(8'h91); send(8'h40); send(8'h7F);
`ifdef OMNI_MODE_EN
        chk("wrongch_on", bus.note_on, 1);
        chk("wrongch_note", bus.note, 64);
        chk("wrongch_vel", bus.velocity, 127);
`else
        chk("wrongch_on", bus.note_on, 0);
        chk("wrongch_note", bus.note, 60);
`endif
        send(8'h81); send(8'h40); send(8'h00);

        send(8'h90); send(8'h3C);
        idle(TMO - 1);
        chk("tmo_early", bus.err_timeout, 0);
        idle(1);
        chk("tmo_pulse", bus.err_timeout, 1);
        send(8'h3E); send(8'h40);
        chk("tmo_resume_on", bus.note_on, 1);
        chk("tmo_resume_note", bus.note, 62);
        send(8'h3E); send(8'h00);

        load_chan(4'd2);
        send(8'h92); send(8'h45); send(8'h10);
        chk("ch2_on", bus.note_on, 1);
        send(8'h90); send(8'h45); send(8'h00);
`ifdef OMNI_MODE_EN
        chk("ch0_off_omni", bus.note_off, 1);
`else
        chk("ch0_ignored", bus.note_off, 0);
        send(8'h92); send(8'h45); send(8'h00);
        chk("ch2_off", bus.note_off, 1);
`endif
        load_chan(4'd0);

        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C); send(8'h40);
        chk("sysx_no_on", bus.note_on, 0);
        chk("sysx_inactive", bus.active, 0);

        send(8'h90); send(8'h3C); send(8'h90); send(8'h40); send(8'h50);
        chk("d2_restart_note", bus.note, 64);
        chk("d2_restart_vel", bus.velocity, 80);
        idle(TMO + 2);
        chk("d2_restart_no_tmo", bus.err_timeout, 0);

        send(8'h90); send(8'h3C); send(8'h64);
        rst_b = 1'b0;
        #1;
        chk("rst_on", bus.note_on, 0);
        chk("rst_active", bus.active, 0);
        chk("rst_note", bus.note, 0);
        chk("rst_vel", bus.velocity, 0);
        idle(2);
        chk("rst_no_off", bus.note_off, 0);
        rst_b = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
